gpio_header_exerciser: RTL and testbench

Header-side driver and checker for the 40-pin GPIO operand/result interface. Drives 8-bit operand pairs onto GPIO[15:8] (A) and GPIO[7:0] (B), tri-states GPIO[31:16], and compares the returned 16-bit result against the expected function selected by MODE. Runs one vector sweep per START and reports pass/fail, error count and the first failing vector. Sits on the board opposite the logic under test, so the header connection can be checked without external equipment.

---
 rtl/gpio_header_exerciser.sv | 169 ++++++++++++++++
 tb/tb_gpio_header_exerciser.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_header_exerciser.sv
// gpio_header_exerciser: drives 8-bit operand pairs onto GPIO[15:0] and checks
// the 16-bit result that the board under test returns on GPIO[31:16].
// One sweep of NUM_VECTORS vectors runs per START pulse.
// Optional feature macro: GPIO_LFSR_VECTORS_EN. When it is defined, the vectors
// come from a 16-bit Fibonacci LFSR seeded with 16'hACE1. When it is not
// defined, the vector is the sweep index.
module gpio_header_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_VECTORS   = 256
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  MODE,
  inout  wire  [31:0] GPIO,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] ERR_COUNT,
  output logic [15:0] FAIL_VEC,
  output logic [15:0] FAIL_GOT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [16:0] LAST_IDX   = 17'(NUM_VECTORS - 1);
  localparam logic [7:0]  SETTLE_LD  = 8'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [16:0] idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] err_q, err_d;
  logic [15:0] fvec_q, fvec_d;
  logic [15:0] fgot_q, fgot_d;
  logic [15:0] sync1_q, sync2_q;
  logic [15:0] vec;
  logic [15:0] exp_val;
  logic        drive_en;

`ifdef GPIO_LFSR_VECTORS_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign vec = lfsr_q;
`else
  assign vec = idx_q[15:0];
`endif

  // The operands are driven only while a vector is in flight.
  assign drive_en     = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign GPIO[15:0]   = drive_en ? vec : 16'hzzzz;
  assign GPIO[31:16]  = 16'hzzzz;

  assign BUSY      = drive_en;
  assign DONE      = (state_q == S_DONE);
  assign PASS      = (state_q == S_DONE) && (err_q == 16'd0);
  assign ERR_COUNT = err_q;
  assign FAIL_VEC  = fvec_q;
  assign FAIL_GOT  = fgot_q;

  // Compute the expected result for the current operands under the latched mode.
  always_comb begin
    exp_val = 16'd0;
    case (mode_q)
      2'd0:    exp_val = vec;
      2'd1:    exp_val = {8'd0, vec[15:8] | vec[7:0]};
      2'd2:    exp_val = {8'd0, vec[15:8] & vec[7:0]};
      default: exp_val = {8'd0, vec[15:8] ^ vec[7:0]};
    endcase
  end

  // Compute the next state and the next value of every sweep register.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fgot_d  = fgot_q;
`ifdef GPIO_LFSR_VECTORS_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          mode_d  = MODE;
          idx_d   = 17'd0;
          err_d   = 16'd0;
          fvec_d  = 16'd0;
          fgot_d  = 16'd0;
`ifdef GPIO_LFSR_VECTORS_EN
          lfsr_d  = 16'hACE1;
`endif
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // Leave once the count reaches zero, which gives SETTLE_CYCLES settle cycles.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sync2_q != exp_val) begin
          if (err_q == 16'd0) begin
            fvec_d = vec;
            fgot_d = sync2_q;
          end
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
        end
`ifdef GPIO_LFSR_VECTORS_EN
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 17'd1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and sweep registers. The returned result passes through a 2-flop synchroniser.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      idx_q   <= 17'd0;
      cnt_q   <= 8'd0;
      err_q   <= 16'd0;
      fvec_q  <= 16'd0;
      fgot_q  <= 16'd0;
      sync1_q <= 16'd0;
      sync2_q <= 16'd0;
`ifdef GPIO_LFSR_VECTORS_EN
      lfsr_q  <= 16'hACE1;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fgot_q  <= fgot_d;
      sync1_q <= GPIO[31:16];
      sync2_q <= sync1_q;
`ifdef GPIO_LFSR_VECTORS_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_gpio_header_exerciser.sv
// Testbench for gpio_header_exerciser. A board model answers on GPIO[31:16].
// A timeline model predicts the outputs every cycle, and directed sweeps pin
// down the literal values.
module tb_gpio_header_exerciser;

  localparam int S   = 4;
  localparam int N   = 256;
  localparam int TOT = N * (S + 2);

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode  = 2'd0;
  wire  [31:0] gpio;
  logic        bsy, dn, ps;
  logic [15:0] ec, fv, fg;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  gpio_header_exerciser #(.SETTLE_CYCLES(S), .NUM_VECTORS(N)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .START    (start),
    .MODE     (mode),
    .GPIO     (gpio),
    .BUSY     (bsy),
    .DONE     (dn),
    .PASS     (ps),
    .ERR_COUNT(ec),
    .FAIL_VEC (fv),
    .FAIL_GOT (fg)
  );

  // Undriven operand pins read as 1, so a released header reads 16'hFFFF.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pu
      pullup pu (gpio[gi]);
    end
  endgenerate

  // Expected function of the logic under test for a given mode.
  function automatic logic [15:0] fn(input logic [1:0] m, input logic [15:0] v);
    case (m)
      2'd0:    return v;
      2'd1:    return {8'd0, v[15:8] | v[7:0]};
      2'd2:    return {8'd0, v[15:8] & v[7:0]};
      default: return {8'd0, v[15:8] ^ v[7:0]};
    endcase
  endfunction

  // Board model: implements hdr_sel, with an optional stuck-at-0 fault on GPIO[16].
  logic [1:0]  hdr_sel   = 2'd0;
  logic        hdr_stuck = 1'b0;
  logic [15:0] hdr_val;
  always_comb begin
    hdr_val = fn(hdr_sel, gpio[15:0]);
    if (hdr_stuck) hdr_val[0] = 1'b0;
  end
  assign gpio[31:16] = hdr_val;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: the expected outputs follow from the cycle count since START.
  logic [15:0] vecs [N];
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [15:0] m_err = 16'd0, m_fv = 16'd0, m_fg = 16'd0;
  logic [15:0] e_err, e_fv, e_fg, lf, v, got;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 16'd0; m_fv = 16'd0; m_fg = 16'd0;
    end else if (start && !m_busy) begin
      m_mode = mode; m_busy = 1'b1; m_done = 1'b0; m_t = 0;
      m_err = 16'd0; m_fv = 16'd0; m_fg = 16'd0;
      e_err = 16'd0; e_fv = 16'd0; e_fg = 16'd0;
      lf = 16'hACE1;
      for (int k = 0; k < N; k++) begin
`ifdef GPIO_LFSR_VECTORS_EN
        v = lf;
`else
        v = k[15:0];
`endif
        vecs[k] = v;
        got = fn(hdr_sel, v) & (hdr_stuck ? 16'hFFFE : 16'hFFFF);
        if (got != fn(m_mode, v)) begin
          if (e_err == 16'd0) begin e_fv = v; e_fg = got; end
          if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
        end
        lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      end
    end else if (m_busy) begin
      m_t++;
      if (m_t == TOT) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_err = e_err; m_fv = e_fv; m_fg = e_fg;
      end
    end
    #1;
    check("busy", bsy, m_busy);
    check("done", dn, m_done);
    check("pass", ps, m_done && (m_err == 16'd0));
    check("gpio_lo", gpio[15:0], m_busy ? vecs[m_t / (S + 2)] : 16'hFFFF);
    if (!m_busy || m_t == 0) begin
      check("err_count", ec, m_err);
      check("fail_vec", fv, m_fv);
      check("fail_got", fg, m_fg);
    end
  end

  // Run one sweep and return the number of cycles from the START cycle until DONE.
  task automatic run(output int cyc_o, input bit clr, input bit flip, input bit mid, input bit cap);
    int cyc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    if (clr) begin
      check("clr_err", ec, 16'd0);
      check("clr_vec", fv, 16'd0);
      check("clr_got", fg, 16'd0);
    end
    while (dn !== 1'b1 && cyc < 3000) begin
`ifdef GPIO_LFSR_VECTORS_EN
      if (cap && cyc == 1)         check("lfsr_v0", gpio[15:0], 16'hACE1);
      if (cap && cyc == 1 + S + 2) check("lfsr_v1", gpio[15:0], 16'h5670);
`endif
      if (flip && cyc == 300) mode = 2'd2;
      if (mid && cyc == 700)  start = 1'b1;
      if (mid && cyc == 701)  start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("sweep_timeout", dn, 1'b1);
    $display("sweep mode=%0d hdr=%0d stuck=%0d cycles=%0d pass=%0d err=%0d fvec=%h fgot=%h",
             m_mode, hdr_sel, hdr_stuck, cyc, ps, ec, fv, fg);
    cyc_o = cyc;
  endtask

  int cyc;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", bsy, 1'b0);
    check("idle_err", ec, 16'd0);

    // Pass-through with a correct board.
    hdr_sel = 2'd0; mode = 2'd0;
    run(cyc, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_mode0", cyc, 1537);
    check("pass_mode0", ps, 1'b1);
    check("err_mode0", ec, 16'd0);

    // XOR with GPIO[16] stuck at 0.
    hdr_sel = 2'd3; hdr_stuck = 1'b1; mode = 2'd3;
    run(cyc, 1'b0, 1'b0, 1'b0, 1'b0);
`ifndef GPIO_LFSR_VECTORS_EN
    check("err_xor", ec, 16'd128);
    check("fvec_xor", fv, 16'h0001);
    check("fgot_xor", fg, 16'h0000);
    check("pass_xor", ps, 1'b0);
`endif

    // Restart from DONE with OR: MODE flips mid-sweep and a second START arrives mid-sweep.
    hdr_stuck = 1'b0; hdr_sel = 2'd1; mode = 2'd1;
    run(cyc, 1'b1, 1'b1, 1'b1, 1'b0);
    check("lat_or", cyc, 1537);
    check("pass_or", ps, 1'b1);

    // Reset while in SETTLE.
    mode = 2'd0; hdr_sel = 2'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bsy, 1'b0);
    check("rst_done", dn, 1'b0);
    check("rst_err", ec, 16'd0);
    check("rst_gpio", gpio[15:0], 16'hFFFF);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("post_rst_busy", bsy, 1'b0);
    check("post_rst_done", dn, 1'b0);

    // AND with a correct board; with LFSR vectors enabled, also checks the first two vectors.
    hdr_sel = 2'd2; mode = 2'd2;
    run(cyc, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lat_and", cyc, 1537);
    check("pass_and", ps, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
